// File: rtl/nf_seven_seg_scan_if.sv
// Debug-display bus of nf_seven_seg_scan: address selection inputs, the
// CPU register read port and the seven-segment pin outputs.
// The slave modport is the display driver; the master modport is the board
// or CPU side that drives the switches and answers register reads.
interface nf_seven_seg_scan_if #(
  parameter int DIGITS = 8
);
  logic              auto;
  logic [4:0]        man_addr;
  logic              step;
  logic [4:0]        reg_addr;
  logic [31:0]       reg_data;
  logic [7:0]        seven_seg;
  logic [DIGITS-1:0] dig;

  modport master (
    output auto, man_addr, step, reg_data,
    input  reg_addr, seven_seg, dig
  );

  modport slave (
    input  auto, man_addr, step, reg_data,
    output reg_addr, seven_seg, dig
  );
endinterface

// File: rtl/nf_seven_seg_scan.sv
// Debug display driver: picks a CPU register address (manual switches or
// auto-scan), snapshots the register once per frame and multiplexes it onto a
// dynamic seven-segment display with blanking between digits, leading-zero
// suppression and a dp marker on digit 0 while auto-scan is active.
module nf_seven_seg_scan #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int DWELL       = 50000000,
  parameter int REG_CNT     = 32,
  parameter int CC_CA       = 0,
  parameter int LZ_BLANK    = 1
) (
  input  logic                clk,
  input  logic                resetn,
  nf_seven_seg_scan_if.slave  bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = $clog2(REFRESH_DIV);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int VW = 4 * DIGITS;

  localparam logic [0:0]        S_BLANK    = 1'b0;
  localparam logic [0:0]        S_DRIVE    = 1'b1;
  localparam logic [4:0]        ADDR_MAX   = 5'(REG_CNT - 1);
  localparam logic [SW-1:0]     SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]     DWELL_LAST = DW'(DWELL - 1);
  localparam logic [IW-1:0]     DIG_LAST   = IW'(DIGITS - 1);
  // XOR masks that turn active-high (common cathode) values into pin levels.
  localparam logic [7:0]        SEG_OFF    = (CC_CA != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF    = (CC_CA != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Hex nibble to {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h3F;  4'h1: code = 7'h06;  4'h2: code = 7'h5B;  4'h3: code = 7'h4F;
      4'h4: code = 7'h66;  4'h5: code = 7'h6D;  4'h6: code = 7'h7D;  4'h7: code = 7'h07;
      4'h8: code = 7'h7F;  4'h9: code = 7'h6F;  4'hA: code = 7'h77;  4'hB: code = 7'h7C;
      4'hC: code = 7'h39;  4'hD: code = 7'h5E;  4'hE: code = 7'h79;  4'hF: code = 7'h71;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

  logic [4:0]        addr_q,      addr_d;
  logic [DW-1:0]     dwell_q,     dwell_d;
  logic              step_prev_q, step_edge_q, step_edge_d;
  logic [31:0]       snap_q,      snap_d;
  logic [0:0]        state_q,     state_d;
  logic [SW-1:0]     slot_q,      slot_d;
  logic [IW-1:0]     idx_q,       idx_d;
  logic [7:0]        seg_q,       seg_d;
  logic [DIGITS-1:0] dig_q,       dig_d;

  logic [4:0]        addr_inc_s;
  logic [4:0]        man_clamp_s;
  logic [VW-1:0]     vis_s;
  logic [VW-1:0]     vis_shift_s;
  logic              lead_blank_s;
  logic [7:0]        seg_on_s;
  logic [DIGITS-1:0] dig_on_s;

  // Address selection: manual clamp, or dwell/step driven auto-scan.
  always_comb begin
    addr_inc_s  = (addr_q == ADDR_MAX) ? 5'd0 : addr_q + 5'd1;
    man_clamp_s = ({1'b0, bus.man_addr} >= 6'(REG_CNT)) ? ADDR_MAX : bus.man_addr;
    step_edge_d = bus.step & ~step_prev_q;
    if (!bus.auto) begin
      addr_d  = man_clamp_s;
      dwell_d = '0;
    end else if (step_edge_q || (dwell_q == DWELL_LAST)) begin
      // A step and the terminal count together still give one increment.
      addr_d  = addr_inc_s;
      dwell_d = '0;
    end else begin
      addr_d  = addr_q;
      dwell_d = dwell_q + DW'(1);
    end
  end

  // Slot timing: 2 blank cycles then drive, index advances at slot end.
  always_comb begin
    slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_BLANK: begin
        if (slot_q == SW'(1)) begin
          state_d = S_DRIVE;
        end else begin
          state_d = S_BLANK;
        end
      end
      S_DRIVE: begin
        if (slot_q == SLOT_LAST) begin
          state_d = S_BLANK;
          idx_d   = (idx_q == DIG_LAST) ? '0 : idx_q + IW'(1);
        end else begin
          state_d = S_DRIVE;
        end
      end
      default: begin
        state_d = S_BLANK;
        idx_d   = '0;
      end
    endcase
    // One coherent value per frame: capture only in the first blank cycle of digit 0.
    if ((state_q == S_BLANK) && (slot_q == '0) && (idx_q == '0)) begin
      snap_d = bus.reg_data;
    end else begin
      snap_d = snap_q;
    end
  end

  // Pin values for the upcoming cycle, computed from next state so the
  // registered outputs line up with the FSM state.
  always_comb begin
    vis_s        = snap_q[VW-1:0];
    vis_shift_s  = vis_s >> {idx_d, 2'b00};
    lead_blank_s = (LZ_BLANK != 0) && (idx_d != '0) && (vis_shift_s == '0);
    if (state_d == S_DRIVE) begin
      seg_on_s[7]   = bus.auto && (idx_d == '0);
      seg_on_s[6:0] = lead_blank_s ? 7'h00 : seg_decode(vis_shift_s[3:0]);
      dig_on_s      = DIGITS'(1) << idx_d;
    end else begin
      seg_on_s = 8'h00;
      dig_on_s = '0;
    end
    seg_d = seg_on_s ^ SEG_OFF;
    dig_d = dig_on_s ^ DIG_OFF;
  end

  // State and output registers; reset drives pins to their off level at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q      <= 5'd0;
      dwell_q     <= '0;
      step_prev_q <= 1'b0;
      step_edge_q <= 1'b0;
      snap_q      <= 32'd0;
      state_q     <= S_BLANK;
      slot_q      <= '0;
      idx_q       <= '0;
      seg_q       <= SEG_OFF;
      dig_q       <= DIG_OFF;
    end else begin
      addr_q      <= addr_d;
      dwell_q     <= dwell_d;
      step_prev_q <= bus.step;
      step_edge_q <= step_edge_d;
      snap_q      <= snap_d;
      state_q     <= state_d;
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
    end
  end

  assign bus.reg_addr  = addr_q;
  assign bus.seven_seg = seg_q;
  assign bus.dig       = dig_q;

endmodule

// File: tb/tb_nf_seven_seg_scan.sv
// Bench for nf_seven_seg_scan: two instances (common cathode with leading-zero
// blanking, common anode without) share the same inputs and register file and
// are compared every cycle against a frame/slot arithmetic model.
module tb_nf_seven_seg_scan;

  localparam int D  = 4;
  localparam int R  = 8;
  localparam int DW = 20;
  localparam int RC = 4;
  localparam int FP = D * R;
  localparam int HN = 4096;

  logic        clk = 1'b0;
  logic        resetn;
  logic        auto_r;
  logic [4:0]  man_r;
  logic        step_r;
  logic [31:0] regs [RC];

  always #5 clk = ~clk;

  nf_seven_seg_scan_if #(.DIGITS(D)) if_a ();
  nf_seven_seg_scan_if #(.DIGITS(D)) if_b ();

  assign if_a.auto     = auto_r;
  assign if_a.man_addr = man_r;
  assign if_a.step     = step_r;
  assign if_a.reg_data = (if_a.reg_addr < 5'd4) ? regs[if_a.reg_addr[1:0]] : 32'hBAD0_BAD0;
  assign if_b.auto     = auto_r;
  assign if_b.man_addr = man_r;
  assign if_b.step     = step_r;
  assign if_b.reg_data = (if_b.reg_addr < 5'd4) ? regs[if_b.reg_addr[1:0]] : 32'hBAD0_BAD0;

  nf_seven_seg_scan #(.DIGITS(D), .REFRESH_DIV(R), .DWELL(DW), .REG_CNT(RC),
                      .CC_CA(0), .LZ_BLANK(1))
    dut_a (.clk(clk), .resetn(resetn), .bus(if_a.slave));

  nf_seven_seg_scan #(.DIGITS(D), .REFRESH_DIV(R), .DWELL(DW), .REG_CNT(RC),
                      .CC_CA(1), .LZ_BLANK(0))
    dut_b (.clk(clk), .resetn(resetn), .bus(if_b.slave));

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Per-cycle history since the last reset release.
  logic [31:0] rd_h   [HN];
  bit          step_h [HN];
  bit          auto_h [HN];

  int          t;
  int          m_addr;
  int          m_dwell;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // Step rising edge as seen by the address logic during cycle tt.
  function automatic bit step_edge(input int tt);
    bit cur, prev;
    cur  = (tt >= 1) ? step_h[tt-1] : 1'b0;
    prev = (tt >= 2) ? step_h[tt-2] : 1'b0;
    return cur && !prev;
  endfunction

  // Expected pins of both instances during cycle tt, from frame arithmetic.
  function automatic void exp_out(input int tt,
                                  output logic [7:0] sa, output logic [3:0] da,
                                  output logic [7:0] sb, output logic [3:0] db);
    int          p, d, s;
    logic [15:0] v;
    logic [3:0]  nib;
    logic        dpv;
    p = tt % FP;
    d = p / R;
    s = p % R;
    if (s < 2) begin
      sa = 8'h00; da = 4'h0; sb = 8'hFF; db = 4'hF;
    end else begin
      v   = rd_h[tt-p][15:0] >> (4 * d);
      nib = v[3:0];
      dpv = (d == 0) && auto_h[tt-1];
      sa  = {dpv, ((d > 0) && (v == 16'h0)) ? 7'h00 : seg_tab[nib]};
      da  = 4'(1 << d);
      sb  = ~{dpv, seg_tab[nib]};
      db  = ~da;
    end
  endfunction

  task automatic do_reset;
    resetn = 1'b0;
    step_r = 1'b0;
    #1;
    check("rst_seg_a", {24'h0, if_a.seven_seg}, 32'h00);
    check("rst_dig_a", {28'h0, if_a.dig},       32'h0);
    check("rst_seg_b", {24'h0, if_b.seven_seg}, 32'hFF);
    check("rst_dig_b", {28'h0, if_b.dig},       32'hF);
    check("rst_addr",  {27'h0, if_a.reg_addr},  32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn  = 1'b1;
    t       = 0;
    m_addr  = 0;
    m_dwell = 0;
  endtask

  // Runs n cycles; the p_* arguments are per-cycle percent chances of a
  // random man_addr change, step toggle and register rewrite.
  task automatic run(input int n, input int p_man, input int p_step, input int p_reg);
    logic [7:0] sa, sb;
    logic [3:0] da, db;
    logic [31:0] val;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      step_h[t] = step_r;
      auto_h[t] = auto_r;
      rd_h[t]   = regs[m_addr];
      check("addr_a", {27'h0, if_a.reg_addr}, 32'(m_addr));
      check("addr_b", {27'h0, if_b.reg_addr}, 32'(m_addr));
      exp_out(t, sa, da, sb, db);
      check("seg_a", {24'h0, if_a.seven_seg}, {24'h0, sa});
      check("dig_a", {28'h0, if_a.dig},       {28'h0, da});
      check("seg_b", {24'h0, if_b.seven_seg}, {24'h0, sb});
      check("dig_b", {28'h0, if_b.dig},       {28'h0, db});
      if (!auto_r) begin
        m_addr  = (man_r >= 5'(RC)) ? RC - 1 : int'(man_r);
        m_dwell = 0;
      end else if (step_edge(t) || (m_dwell == DW - 1)) begin
        m_addr  = (m_addr + 1) % RC;
        m_dwell = 0;
      end else begin
        m_dwell++;
      end
      t++;
      @(posedge clk);
      #1;
      if ($urandom_range(0, 99) < p_man)  man_r  = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < p_step) step_r = ~step_r;
      if ($urandom_range(0, 99) < p_reg) begin
        val = $urandom & (32'hFFFF_FFFF >> (4 * $urandom_range(4, 8)));
        regs[$urandom_range(0, RC - 1)] = val;
      end
    end
  endtask

  initial begin
    resetn  = 1'b0;
    auto_r  = 1'b0;
    man_r   = 5'd0;
    step_r  = 1'b0;
    regs[0] = 32'h0000_1234;
    regs[1] = 32'h0000_0005;
    regs[2] = 32'h0000_0000;
    regs[3] = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    do_reset();

    // Manual frames: 0x1234, then 0x5 (leading zeros), then 0.
    run(2 * FP + 6, 0, 0, 0);
    man_r = 5'd1;
    run(2 * FP, 0, 0, 0);
    man_r = 5'd2;
    run(2 * FP, 0, 0, 0);
    // Out-of-range manual address clamps to the last register.
    man_r = 5'd7;
    run(FP + 8, 0, 0, 0);
    // Random manual addresses with registers rewritten mid-frame.
    run(200, 5, 0, 10);

    // Auto-scan from the current address, man_addr wandering.
    auto_r = 1'b1;
    run(100, 20, 0, 0);
    // Single step pulse, then step held high for 10 cycles.
    run(5, 0, 0, 0);
    step_r = 1'b1;
    run(1, 0, 0, 0);
    step_r = 1'b0;
    run(40, 0, 0, 0);
    step_r = 1'b1;
    run(10, 0, 0, 0);
    step_r = 1'b0;
    run(40, 0, 0, 0);
    // Random steps and register changes in auto mode.
    run(400, 0, 8, 10);
    step_r = 1'b0;
    run(3, 0, 0, 0);

    // Mode switches both ways.
    auto_r = 1'b0;
    run(40, 10, 0, 5);
    auto_r = 1'b1;
    run(60, 0, 0, 5);

    // Reset fresh from auto, then asynchronous reset in the middle of a drive slot.
    do_reset();
    run(100, 0, 0, 0);
    while ((t % R) < 3) run(1, 0, 0, 0);
    do_reset();
    auto_r = 1'b0;
    man_r  = 5'd3;
    run(2 * FP + 4, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
